// File: rtl/risc_pkg.sv
// Shared definitions for the small RISC core: opcodes, sequencer states,
// datapath widths and the bundle of control strobes issued each cycle.
package risc_pkg;

  localparam int INSTR_W  = 16;
  localparam int ADDR_W   = 13;
  localparam int OPCODE_W = 3;
  localparam int STATE_W  = 4;

  typedef enum logic [OPCODE_W-1:0] {
    HLT = 3'b000,
    SKZ = 3'b001,
    ADD = 3'b010,
    AND = 3'b011,
    XOR = 3'b100,
    LDA = 3'b101,
    STO = 3'b110,
    JMP = 3'b111
  } opcode_t;

  typedef enum logic [STATE_W-1:0] {
    S0   = 4'd0,
    S1   = 4'd1,
    S2   = 4'd2,
    S3   = 4'd3,
    S4   = 4'd4,
    S5   = 4'd5,
    S6   = 4'd6,
    S7   = 4'd7,
    HALT = 4'd8
  } state_t;

  typedef struct packed {
    logic inc_pc;
    logic load_pc;
    logic load_ir;
    logic load_acc;
    logic rd;
    logic wr;
    logic datactl_ena;
    logic halt;
  } ctrl_t;

  // Opcodes that read an operand from memory and write the accumulator.
  function automatic logic is_alu(input opcode_t op);
    return op inside {ADD, AND, XOR, LDA};
  endfunction

endpackage

// File: rtl/ctrl_decode.sv
// Combinational row table of the instruction sequencer: given the current
// state, opcode and zero flag, produce the next state and the control row.
module ctrl_decode
  import risc_pkg::*;
(
  input  state_t     state,
  input  logic [2:0] opcode,
  input  logic       zero,
  output state_t     next_state,
  output ctrl_t      row
);

  opcode_t op;
  assign op = opcode_t'(opcode);

  always_comb begin
    // NOTE: every output gets a default before the case, so no path can
    // leave a signal unassigned and infer a latch.
    row        = '0;
    next_state = S0;
    case (state)
      S0: begin
        row.rd      = 1'b1;
        row.load_ir = 1'b1;
        next_state  = S1;
      end
      S1: begin
        row.rd      = 1'b1;
        row.load_ir = 1'b1;
        row.inc_pc  = 1'b1;
        next_state  = S2;
      end
      S2: next_state = S3;
      S3: begin
        row.inc_pc = 1'b1;
        if (op == HLT) begin
          row.halt   = 1'b1;
          next_state = HALT;
        end else begin
          next_state = S4;
        end
      end
      S4: begin
        row.load_pc     = (op == JMP);
        row.rd          = is_alu(op);
        row.datactl_ena = (op == STO);
        next_state      = S5;
      end
      S5: begin
        row.rd          = is_alu(op);
        row.load_acc    = is_alu(op);
        row.load_pc     = (op == JMP);
        row.inc_pc      = (op == JMP) || ((op == SKZ) && zero);
        row.wr          = (op == STO);
        row.datactl_ena = (op == STO);
        next_state      = S6;
      end
      S6: begin
        row.rd          = is_alu(op);
        row.datactl_ena = (op == STO);
        next_state      = S7;
      end
      // Second PC advance of a taken skip; row 6 keeps it apart from row 5.
      S7: begin
        row.inc_pc = (op == SKZ) && zero;
        next_state = S0;
      end
      HALT: begin
        row.halt   = 1'b1;
        next_state = HALT;
      end
      default: next_state = S0;
    endcase
  end

endmodule

// File: rtl/machine_ctrl.sv
// Instruction sequencer: registers the state and the control row chosen by
// ctrl_decode, so every strobe comes straight from a flop.
module machine_ctrl
  import risc_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       ena,
  input  logic [2:0] opcode,
  input  logic       zero,
  output logic       inc_pc,
  output logic       load_pc,
  output logic       load_ir,
  output logic       load_acc,
  output logic       rd,
  output logic       wr,
  output logic       datactl_ena,
  output logic       halt,
  output logic [3:0] state
);

  state_t state_q;
  state_t next_state;
  ctrl_t  ctrl_q;
  ctrl_t  row;

  ctrl_decode u_decode (
    .state      (state_q),
    .opcode     (opcode),
    .zero       (zero),
    .next_state (next_state),
    .row        (row)
  );

  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every flop samples pre-edge values.
    if (reset) begin
      state_q <= S0;
      ctrl_q  <= '0;
    end else if (state_q == HALT || ena) begin
      // HALT is sticky and ignores ena; only reset leaves it.
      state_q <= next_state;
      ctrl_q  <= row;
    end else begin
      state_q <= S0;
      ctrl_q  <= '0;
    end
  end

  assign inc_pc      = ctrl_q.inc_pc;
  assign load_pc     = ctrl_q.load_pc;
  assign load_ir     = ctrl_q.load_ir;
  assign load_acc    = ctrl_q.load_acc;
  assign rd          = ctrl_q.rd;
  assign wr          = ctrl_q.wr;
  assign datactl_ena = ctrl_q.datactl_ena;
  assign halt        = ctrl_q.halt;
  assign state       = state_q;

endmodule
